// File: rtl/conv_line_buffer.sv
// Streaming line buffer for a KERN_DIM x KERN_DIM convolver.
// Stores the previous KERN_DIM-1 rows and emits one registered vertical
// column per accepted pixel, tagged with window/row/frame position flags.
module conv_line_buffer #(
  parameter int KERN_DIM = 3,
  parameter int WIDTH    = 28,
  parameter int HEIGHT   = 28,
  parameter int DATA_BW  = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_BW-1:0]          in_pixel,
  input  logic                        in_sof,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [KERN_DIM*DATA_BW-1:0] out_col,
  output logic                        window_valid,
  output logic                        row_start,
  output logic                        frame_done
);

  localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST      = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST      = RW'(HEIGHT - 1);
  localparam logic [CW-1:0] COL_WIN       = CW'(KERN_DIM - 1);
  localparam logic [RW-1:0] ROW_WIN       = RW'(KERN_DIM - 1);
  localparam logic [RW-1:0] ROW_FILL_LAST = RW'(KERN_DIM - 2);

  typedef enum logic {FILL, STREAM} state_t;

  state_t state, state_next;

  logic [CW-1:0] col, pos_col, col_next;
  logic [RW-1:0] row, pos_row, row_next;
  logic          accept, col_last, row_last;
  logic          wv_d, rs_d, fd_d;
  logic [KERN_DIM*DATA_BW-1:0] new_col;

  // lb[k][c] holds the pixel from row r-1-k at column c
  logic [DATA_BW-1:0] lb [KERN_DIM-1][WIDTH];

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Start-of-frame overrides the tracked position with (0,0)
  assign pos_col  = in_sof ? '0 : col;
  assign pos_row  = in_sof ? '0 : row;
  assign col_last = (pos_col == COL_LAST);
  assign row_last = (pos_row == ROW_LAST);

  assign wv_d = (state == STREAM) && (pos_row >= ROW_WIN) && (pos_col >= COL_WIN);
  assign rs_d = (pos_col == '0);
  assign fd_d = row_last && col_last;

  // Next raster position after the accepted pixel
  always_comb begin
    col_next = pos_col + CW'(1);
    row_next = pos_row;
    if (col_last) begin
      col_next = '0;
      row_next = row_last ? '0 : pos_row + RW'(1);
    end
  end

  // Assemble the outgoing column: newest pixel in slice 0, oldest row on top
  always_comb begin
    new_col = '0;
    new_col[DATA_BW-1:0] = in_pixel;
    for (int k = 1; k < KERN_DIM; k++) begin
      new_col[k*DATA_BW +: DATA_BW] = lb[k-1][pos_col];
    end
  end

  // FILL until the first KERN_DIM-1 rows are stored, then STREAM to frame end
  always_comb begin
    state_next = state;
    if (accept) begin
      if (pos_row == ROW_FILL_LAST && col_last) begin
        state_next = STREAM;
      end else if (in_sof || fd_d) begin
        state_next = FILL;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= FILL;
    end else begin
      state <= state_next;
    end
  end

  // Raster position counters, advanced only on accept
  always_ff @(posedge clk) begin
    if (!reset) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      col <= col_next;
      row <= row_next;
    end
  end

  // Line memory: shift the column at pos_col down by one row
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < KERN_DIM-1; k++) begin
        for (int c = 0; c < WIDTH; c++) begin
          lb[k][c] <= '0;
        end
      end
    end else if (accept) begin
      lb[0][pos_col] <= in_pixel;
      for (int k = 1; k < KERN_DIM-1; k++) begin
        lb[k][pos_col] <= lb[k-1][pos_col];
      end
    end
  end

  // Output register: load on accept, hold on stall, drain when consumed
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid    <= 1'b0;
      out_col      <= '0;
      window_valid <= 1'b0;
      row_start    <= 1'b0;
      frame_done   <= 1'b0;
    end else if (accept) begin
      out_valid    <= 1'b1;
      out_col      <= new_col;
      window_valid <= wv_d;
      row_start    <= rs_d;
      frame_done   <= fd_d;
    end else if (out_ready) begin
      out_valid    <= 1'b0;
      window_valid <= 1'b0;
      row_start    <= 1'b0;
      frame_done   <= 1'b0;
    end
  end

endmodule

// File: doc/conv_line_buffer.md
# conv_line_buffer

Streaming line buffer that sits directly upstream of the convolver control path and datapath. It accepts a raster-order pixel stream over a valid/ready handshake and stores the previous KERN_DIM-1 image rows. For every accepted pixel it emits one registered vertical column of KERN_DIM pixels, which the downstream stage shifts into its window. It also tags the columns that complete a fully in-image KERN_DIM x KERN_DIM window.

## Interface
- KERN_DIM, 3, kernel height and width in pixels; must be ≥ 2
- WIDTH, 28, image width in pixels
- HEIGHT, 28, image height in pixels; must be ≥ KERN_DIM
- DATA_BW, 8, pixel width in bits
- clk  in  1  single clock; all logic on the rising edge
- reset  in  1  synchronous, active-low reset (sampled on the rising edge of clk)
- in_valid  in  1  in_pixel is valid
- in_ready  out  1  block can accept a pixel this cycle
- in_pixel  in  DATA_BW  pixel value, raster order
- in_sof  in  1  start of frame; forces the accepted pixel to position (0,0)
- out_valid  out  1  out_col and its tags are valid
- out_ready  in  1  downstream consumes the output this cycle
- out_col  out  KERN_DIM*DATA_BW  column; slice k (bits (k+1)*DATA_BW-1 : k*DATA_BW) is the pixel from row r-k at column c; slice 0 is the newest pixel
- window_valid  out  1  column completes a full window (r ≥ KERN_DIM-1 and c ≥ KERN_DIM-1)
- row_start  out  1  column is at c = 0
- frame_done  out  1  column is the last pixel of the frame (r = HEIGHT-1, c = WIDTH-1)

## Operation
- Accept occurs when in_valid && in_ready. in_ready = !out_valid || out_ready.
- Line memory: KERN_DIM-1 rows × WIDTH entries, lb[k][c] for k = 0..KERN_DIM-2. lb[0] holds row r-1.
- On accept at column c:
  - out_col = {lb[KERN_DIM-2][c], …, lb[0][c], in_pixel}
  - then lb[0][c] ← in_pixel and lb[k][c] ← lb[k-1][c] for k ≥ 1.
- Position counters col (0..WIDTH-1) and row (0..HEIGHT-1) advance only on accept:
  - col wraps at WIDTH-1 and increments row.
  - row wraps at HEIGHT-1 to 0, beginning the next frame.
- in_sof on an accepted pixel treats that pixel as (0,0):
  - tags are computed for (0,0);
  - counters become col = 1, row = 0 (col = 0, row = 1 if WIDTH = 1);
  - the state machine enters FILL.
  - Line memory is not cleared.
- State machine:
  - FILL (row < KERN_DIM-1) → STREAM on accept of the last pixel of row KERN_DIM-2.
  - STREAM → FILL on accept of the frame's last pixel, or on in_sof.
  - window_valid is forced to 0 in FILL.
- The tags (window_valid, row_start, frame_done) are computed from the accepted pixel's position and registered with out_col.
- Line memory contents carry across frames. Columns from rows < KERN_DIM-1 may show previous-frame data, but they are never window_valid.

## Timing
- Reset (reset = 0 at an edge):
  - out_valid = 0, out_col = 0, window_valid = 0, row_start = 0, frame_done = 0
  - row = col = 0, state = FILL, all lb entries cleared to 0
  - in_ready = 1 from the first cycle after reset deasserts.
- Latency: a pixel accepted at edge N appears on out_col with out_valid = 1 after edge N, i.e. 1 cycle.
- Throughput: 1 pixel/cycle with out_ready held high; there is no bubble at row or frame boundaries.
- Stall: while out_valid && !out_ready:
  - in_ready = 0;
  - out_col, tags and line memory hold;
  - no pixel is dropped or duplicated.
- Simultaneous output consume and input accept: outputs are replaced by the new column in the same edge.
- If no accept occurs and out_ready = 1, out_valid falls to 0.
- Reset mid-frame: reset overrides any handshake in that cycle. In-flight output is discarded, and the next accepted pixel is (0,0).
- frame_done and row_start are qualified by out_valid and asserted for exactly one output beat each.

## Test plan
- Reset: hold reset = 0 for 2 cycles with in_valid = 1 → out_valid = 0, out_col = 0, and no accept. After release, in_ready = 1.
- Full frame, ramp: stream pixel(r,c) = (r*28+c) mod 256 continuously with out_ready = 1 (defaults) → expect all of:
  - beat for (2,5) shows out_col = {5,33,61} (slice 2 down to slice 0);
  - first window_valid at beat 59, pixel (2,2);
  - exactly 676 window_valid beats;
  - 28 row_start beats;
  - frame_done only on beat 784.
- Backpressure: drop out_ready for 3 cycles at pixel (10,4) → in_ready = 0 and out_col stable for those 3 cycles. The resumed sequence matches the ramp model with no loss or duplication.
- Resync: assert in_sof on the pixel at position (1,10) → that beat has row_start = 1 and window_valid = 0. The next window_valid occurs 58 accepts later.
- Reset mid-frame: reset at pixel (15,7), then restart the ramp → the first output is row_start with out_col = {0,0,0}, and the first window_valid is at beat 59.
- Back-to-back frames: send two frames with no idle cycle → the second frame shows its first window_valid at its beat 59, and exactly one frame_done per frame.
